// File: rtl/drone_top.sv
// drone_top: X-frame quadcopter mixer feeding a per-motor integral speed loop.
// Define DRONE_FAILSAFE_EN to add the fault output that zeroes motors after 3 consecutive bad ticks.
module drone_top #(
    parameter int RPM_MAX    = 12000,
    parameter int DIR_DELTA  = 500,
    parameter int KSHIFT     = 2,
    parameter int UPDATE_DIV = 4,
    parameter int SET_MAX    = 65535
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic signed [15:0] altcmd,
    input  logic        [2:0]  dircmd,
    input  logic signed [15:0] rpm_sense [3:0],
`ifdef DRONE_FAILSAFE_EN
    output logic               fault,
`endif
    output logic        [15:0] mot_set [3:0]
);
    localparam int CW = $clog2(UPDATE_DIV + 1);
    localparam logic signed [17:0] D18   = 18'(DIR_DELTA);
    localparam logic signed [17:0] MAX18 = 18'(RPM_MAX);
    localparam logic signed [18:0] SMAX  = 19'(SET_MAX);

    logic [CW-1:0] cnt;
    logic tick;
    logic kill;
    logic [3:0] plus;
    logic dir_en;
    logic signed [17:0] base;
    logic signed [17:0] mix [3:0];
    logic [15:0] tgt_n [3:0];
    logic [15:0] tgt [3:0];
    logic signed [17:0] err [3:0];
    logic signed [17:0] step [3:0];
    logic signed [18:0] sum [3:0];
    logic [15:0] nxt [3:0];

    assign tick   = cnt == CW'(UPDATE_DIV - 1);
    assign dir_en = (dircmd != 3'd0) && (dircmd != 3'd7);
    assign base   = altcmd[15] ? 18'sd0 : $signed({2'b00, altcmd});

    // plus[i] set: motor i gets +D, otherwise -D (only when dir_en)
    always_comb begin
        plus = 4'b0000;
        case (dircmd)
            3'd1:    plus = 4'b1100;
            3'd2:    plus = 4'b0011;
            3'd3:    plus = 4'b0110;
            3'd4:    plus = 4'b1001;
            3'd5:    plus = 4'b1010;
            3'd6:    plus = 4'b0101;
            default: plus = 4'b0000;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            mix[i]   = base + (!dir_en ? 18'sd0 : plus[i] ? D18 : -D18);
            tgt_n[i] = mix[i][17] ? 16'd0 : mix[i] > MAX18 ? MAX18[15:0] : mix[i][15:0];
            err[i]   = $signed({2'b00, tgt[i]}) - $signed({{2{rpm_sense[i][15]}}, rpm_sense[i]});
            step[i]  = err[i] >>> KSHIFT;
            sum[i]   = $signed({3'b000, mot_set[i]}) + $signed({step[i][17], step[i]});
            nxt[i]   = sum[i][18] ? 16'd0 : sum[i] > SMAX ? SMAX[15:0] : sum[i][15:0];
        end
    end

`ifdef DRONE_FAILSAFE_EN
    logic [1:0] bad;
    logic any_neg;
    assign any_neg = rpm_sense[0][15] | rpm_sense[1][15] | rpm_sense[2][15] | rpm_sense[3][15];
    // kill covers the tripping tick itself so motors drop in the same edge fault rises
    assign kill = fault | (tick & any_neg & (bad == 2'd2));
    always_ff @(posedge clk) begin
        if (resetn) begin
            bad   <= 2'd0;
            fault <= 1'b0;
        end else begin
            if (tick) bad <= any_neg ? bad + 2'd1 : 2'd0;
            fault <= kill;
        end
    end
`else
    assign kill = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (resetn) begin
            cnt <= '0;
            for (int i = 0; i < 4; i++) begin
                tgt[i]     <= 16'd0;
                mot_set[i] <= 16'd0;
            end
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            for (int i = 0; i < 4; i++) begin
                tgt[i] <= tgt_n[i];
                if (kill) mot_set[i] <= 16'd0;
                else if (tick) mot_set[i] <= nxt[i];
            end
        end
    end
endmodule

// File: tb/tb_drone_top.sv
// tb_drone_top: table vectors, hand sequences and random stimulus against an arithmetic model of drone_top.
module tb_drone_top;
    localparam int RPM_MAX = 12000, D = 500, KDIV = 4, DIV = 4, SET_MAX = 65535;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               resetn;
    logic signed [15:0] altcmd;
    logic        [2:0]  dircmd;
    logic signed [15:0] rpm_sense [3:0];
    logic        [15:0] mot_set [3:0];
`ifdef DRONE_FAILSAFE_EN
    logic               fault;
`endif

    drone_top dut (
        .clk(clk),
        .resetn(resetn),
        .altcmd(altcmd),
        .dircmd(dircmd),
        .rpm_sense(rpm_sense),
`ifdef DRONE_FAILSAFE_EN
        .fault(fault),
`endif
        .mot_set(mot_set)
    );

    int checks = 0, errors = 0;
    int m_tgt [4], m_set [4];
    int m_ph, m_bad;
    bit m_fault;
    int sgn [8][4] = '{'{0, 0, 0, 0}, '{-1, -1, 1, 1}, '{1, 1, -1, -1}, '{-1, 1, 1, -1},
                       '{1, -1, -1, 1}, '{-1, 1, -1, 1}, '{1, -1, 1, -1}, '{0, 0, 0, 0}};

    typedef struct {
        int alt, dir;
        int r0, r1, r2, r3;
        int e0, e1, e2, e3;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic model_step();
        bit tick, neg;
        int e, s, v, b, t;
        tick = (m_ph == DIV - 1);
        neg = 1'b0;
        if (resetn) begin
            for (int i = 0; i < 4; i++) begin
                m_tgt[i] = 0;
                m_set[i] = 0;
            end
            m_ph = 0;
            m_bad = 0;
            m_fault = 1'b0;
            return;
        end
        if (tick) begin
            for (int i = 0; i < 4; i++) begin
                e = m_tgt[i] - int'(rpm_sense[i]);
                s = e >= 0 ? e / KDIV : -((-e + KDIV - 1) / KDIV);
                v = m_set[i] + s;
                m_set[i] = v < 0 ? 0 : v > SET_MAX ? SET_MAX : v;
                if (rpm_sense[i] < 0) neg = 1'b1;
            end
`ifdef DRONE_FAILSAFE_EN
            m_bad = neg ? m_bad + 1 : 0;
            if (m_bad >= 3) m_fault = 1'b1;
`endif
        end
        if (m_fault) for (int i = 0; i < 4; i++) m_set[i] = 0;
        m_ph = (m_ph + 1) % DIV;
        b = altcmd < 0 ? 0 : int'(altcmd);
        for (int i = 0; i < 4; i++) begin
            t = b + sgn[dircmd][i] * D;
            m_tgt[i] = t < 0 ? 0 : t > RPM_MAX ? RPM_MAX : t;
        end
    endtask

    task automatic cyc(input string nm);
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) chk(nm, int'(mot_set[i]), m_set[i]);
`ifdef DRONE_FAILSAFE_EN
        chk({nm, "_fault"}, int'(fault), int'(m_fault));
`endif
    endtask

    task automatic set_in(input int alt, input int dir, input int r0, input int r1, input int r2, input int r3);
        altcmd = 16'(alt);
        dircmd = 3'(dir);
        rpm_sense[0] = 16'(r0);
        rpm_sense[1] = 16'(r1);
        rpm_sense[2] = 16'(r2);
        rpm_sense[3] = 16'(r3);
    endtask

    task automatic do_reset(input int n);
        resetn = 1'b1;
        repeat (n) cyc("reset");
        resetn = 1'b0;
    endtask

    task automatic chk4(input string nm, input int e0, input int e1, input int e2, input int e3);
        chk({nm, "_m0"}, int'(mot_set[0]), e0);
        chk({nm, "_m1"}, int'(mot_set[1]), e1);
        chk({nm, "_m2"}, int'(mot_set[2]), e2);
        chk({nm, "_m3"}, int'(mot_set[3]), e3);
    endtask

    initial begin
        tbl[0] = '{4000, 0, 0, 0, 0, 0, 2000, 2000, 2000, 2000};
        tbl[1] = '{-100, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2] = '{12000, 1, 0, 0, 0, 0, 5750, 5750, 6000, 6000};
        tbl[3] = '{4000, 3, 0, 0, 0, 0, 1750, 2250, 2250, 1750};
        tbl[4] = '{4000, 7, 0, 0, 0, 0, 2000, 2000, 2000, 2000};
        tbl[5] = '{0, 2, 0, 0, 0, 0, 250, 250, 0, 0};
        tbl[6] = '{1000, 0, 1003, 1000, 0, -1000, 0, 0, 500, 1000};
        tbl[7] = '{4000, 5, 0, 0, 0, 0, 1750, 2250, 1750, 2250};
        tbl[8] = '{4000, 6, 0, 0, 0, 0, 2250, 1750, 2250, 1750};
        tbl[9] = '{4000, 4, 0, 0, 0, 0, 2250, 1750, 1750, 2250};

        set_in(4000, 0, 0, 0, 0, 0);
        do_reset(2);
        chk4("reset_hold", 0, 0, 0, 0);
        repeat (3) cyc("pre_tick");
        chk4("pre_first_tick", 0, 0, 0, 0);
        cyc("first_tick");
        chk4("first_tick", 1000, 1000, 1000, 1000);
        repeat (4) cyc("second_tick");
        chk4("second_tick", 2000, 2000, 2000, 2000);

        for (int k = 0; k < 10; k++) begin
            set_in(tbl[k].alt, tbl[k].dir, tbl[k].r0, tbl[k].r1, tbl[k].r2, tbl[k].r3);
            do_reset(1);
            repeat (8) cyc("tbl");
            chk4($sformatf("tbl%0d", k), tbl[k].e0, tbl[k].e1, tbl[k].e2, tbl[k].e3);
        end

        set_in(4000, 0, 0, 0, 0, 0);
        do_reset(1);
        repeat (16) cyc("preload");
        chk4("preload", 4000, 4000, 4000, 4000);
        set_in(4000, 1, 4000, 4000, 4000, 4000);
        repeat (4) cyc("fwd1");
        chk4("fwd1", 3875, 3875, 4125, 4125);
        repeat (4) cyc("fwd2");
        chk4("fwd2", 3750, 3750, 4250, 4250);

        set_in(12000, 0, 0, 0, 0, 0);
        do_reset(1);
        repeat (88) cyc("sat_up");
        chk4("sat_hi", 65535, 65535, 65535, 65535);
        repeat (8) cyc("sat_hold");
        chk4("sat_hold", 65535, 65535, 65535, 65535);
        resetn = 1'b1;
        cyc("mid_reset");
        chk4("mid_reset", 0, 0, 0, 0);
        resetn = 1'b0;

`ifdef DRONE_FAILSAFE_EN
        set_in(4000, 0, 0, 0, -1, 0);
        do_reset(1);
        repeat (12) cyc("fs_trip");
        chk("fs_trip_fault", int'(fault), 1);
        chk4("fs_trip", 0, 0, 0, 0);
        set_in(4000, 0, 0, 0, 0, 0);
        repeat (8) cyc("fs_hold");
        chk("fs_hold_fault", int'(fault), 1);
        chk4("fs_hold", 0, 0, 0, 0);

        set_in(4000, 0, 0, 0, -1, 0);
        do_reset(1);
        repeat (8) cyc("fs_bad");
        set_in(4000, 0, 0, 0, 0, 0);
        repeat (4) cyc("fs_good");
        set_in(4000, 0, 0, 0, -1, 0);
        repeat (8) cyc("fs_bad2");
        chk("fs_interleave_fault", int'(fault), 0);
        chk("fs_interleave_m0", int'(mot_set[0]), 5000);
`endif

        set_in(0, 0, 0, 0, 0, 0);
        do_reset(1);
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                altcmd = 16'($urandom_range(0, 16000) - 2000);
                dircmd = 3'($urandom_range(0, 7));
                for (int i = 0; i < 4; i++)
                    rpm_sense[i] = ($urandom_range(0, 15) == 0) ? 16'(-int'($urandom_range(1, 32768)))
                                                                 : 16'($urandom_range(0, 20000));
            end
            resetn = ($urandom_range(0, 149) == 0);
            cyc("rand");
        end
        resetn = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
